axis_pkt_gen: RTL and testbench

- AXI-Stream packet transmitter that drives the s_axis side of the team's AXIS FIFO in test and bring-up designs.
- Generates a programmed number of packets of programmable byte length with a deterministic incrementing data pattern.
- Honours backpressure and inserts a programmable idle gap between packets.
- Single clock domain, same clock as the FIFO it feeds.

---
 rtl/axis_pkt_gen_if.sv | 23 ++
 rtl/axis_pkt_gen.sv | 238 +++++++++++++++++++++++
 tb/tb_axis_pkt_gen.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pkt_gen_if.sv
// ============================================================================
// Module   : axis_pkt_gen_if
// Purpose  : AXI-Stream bus bundle between axis_pkt_gen and its sink.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axis_pkt_gen_if #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = DATA_W / 8
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic              tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

`default_nettype wire

// File: rtl/axis_pkt_gen.sv
// ============================================================================
// Module   : axis_pkt_gen
// Purpose  : AXI-Stream packet generator with incrementing data and idle gaps.
//            Optional abort input enabled by AXIS_PKT_GEN_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_pkt_gen #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = DATA_W / 8,
  parameter int LEN_W  = 16,
  parameter int GAP_W  = 8
) (
  input  wire logic              aclk,
  input  wire logic              areset,
  input  wire logic              start,
  input  wire logic [LEN_W-1:0]  pkt_len_bytes,
  input  wire logic [15:0]       pkt_count,
  input  wire logic [GAP_W-1:0]  gap_cycles,
  input  wire logic [DATA_W-1:0] seed,
`ifdef AXIS_PKT_GEN_ABORT_EN
  input  wire logic              abort,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            pkts_sent,
  axis_pkt_gen_if.master         m_axis
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Index of the final beat of a packet: ceil(len/KEEP_W) - 1.
  function automatic logic [LEN_W-1:0] last_idx_f(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] beats;
    beats = ({1'b0, len} + (LEN_W+1)'(KEEP_W - 1)) / (LEN_W+1)'(KEEP_W);
    return LEN_W'(beats - (LEN_W+1)'(1));
  endfunction

  function automatic logic [KEEP_W-1:0] last_keep_f(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0]  rem;
    logic [KEEP_W-1:0] keep;
    rem  = len % LEN_W'(KEEP_W);
    keep = '1;
    if (rem != '0) begin
      for (int i = 0; i < KEEP_W; i++) keep[i] = (LEN_W'(i) < rem);
    end
    return keep;
  endfunction

  logic [1:0]        state_q,     state_d;
  logic [LEN_W-1:0]  last_idx_q,  last_idx_d;
  logic [KEEP_W-1:0] last_keep_q, last_keep_d;
  logic [15:0]       count_q,     count_d;
  logic [GAP_W-1:0]  gap_q,       gap_d;
  logic [GAP_W-1:0]  gap_cnt_q,   gap_cnt_d;
  logic [LEN_W-1:0]  beat_q,      beat_d;
  logic [15:0]       pkts_q,      pkts_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic              valid_q,     valid_d;
  logic [DATA_W-1:0] data_q,      data_d;
  logic [KEEP_W-1:0] keep_q,      keep_d;
  logic              last_q,      last_d;
  logic              user_q,      user_d;
  logic              load_beat;
  logic [LEN_W-1:0]  next_beat;
  logic              abort_now;

`ifdef AXIS_PKT_GEN_ABORT_EN
  // Abort is sticky for the rest of the run so a one-cycle pulse is never lost.
  logic abort_q, abort_d;

  always_comb begin
    abort_d = abort_q;
    if (state_q == S_IDLE) begin
      abort_d = 1'b0;
    end else if (state_q == S_SEND || state_q == S_GAP) begin
      abort_d = abort_q | abort;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) abort_q <= 1'b0;
    else        abort_q <= abort_d;
  end

  assign abort_now = abort_q | abort;
`else
  assign abort_now = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    last_idx_d  = last_idx_q;
    last_keep_d = last_keep_q;
    count_d     = count_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    beat_d      = beat_q;
    pkts_d      = pkts_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    valid_d     = valid_q;
    data_d      = data_q;
    keep_d      = keep_q;
    last_d      = last_q;
    user_d      = user_q;
    load_beat   = 1'b0;
    next_beat   = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pkts_d = '0;
          if (pkt_len_bytes != '0 && pkt_count != '0) begin
            last_idx_d  = last_idx_f(pkt_len_bytes);
            last_keep_d = last_keep_f(pkt_len_bytes);
            count_d     = pkt_count;
            gap_d       = gap_cycles;
            data_d      = seed;
            busy_d      = 1'b1;
            load_beat   = 1'b1;
            state_d     = S_SEND;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_SEND: begin
        if (valid_q && m_axis.tready) begin
          data_d = data_q + DATA_W'(1);
          if (last_q) begin
            pkts_d = pkts_q + 16'd1;
            if (pkts_q + 16'd1 == count_q || abort_now) begin
              valid_d = 1'b0;
              last_d  = 1'b0;
              user_d  = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_DONE;
            end else if (gap_q == '0) begin
              load_beat = 1'b1;
            end else begin
              valid_d   = 1'b0;
              last_d    = 1'b0;
              user_d    = 1'b0;
              gap_cnt_d = '0;
              state_d   = S_GAP;
            end
          end else begin
            load_beat = 1'b1;
            next_beat = beat_q + LEN_W'(1);
          end
        end
      end

      S_GAP: begin
        if (abort_now) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (gap_cnt_q == gap_q - GAP_W'(1)) begin
          load_beat = 1'b1;
          state_d   = S_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Present beat next_beat of a packet; uses the freshly latched length in IDLE.
    if (load_beat) begin
      beat_d  = next_beat;
      valid_d = 1'b1;
      user_d  = (next_beat == '0);
      last_d  = (next_beat == last_idx_d);
      keep_d  = (next_beat == last_idx_d) ? last_keep_d : '1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= S_IDLE;
      last_idx_q  <= '0;
      last_keep_q <= '0;
      count_q     <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      beat_q      <= '0;
      pkts_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      keep_q      <= '0;
      last_q      <= 1'b0;
      user_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_idx_q  <= last_idx_d;
      last_keep_q <= last_keep_d;
      count_q     <= count_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      beat_q      <= beat_d;
      pkts_q      <= pkts_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      keep_q      <= keep_d;
      last_q      <= last_d;
      user_q      <= user_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pkts_sent     = pkts_q;
  assign m_axis.tvalid = valid_q;
  assign m_axis.tdata  = data_q;
  assign m_axis.tkeep  = keep_q;
  assign m_axis.tlast  = last_q;
  assign m_axis.tuser  = user_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_pkt_gen.sv
// ============================================================================
// Module   : tb_axis_pkt_gen
// Purpose  : Scoreboard bench for axis_pkt_gen (abort scenario built only
//            when AXIS_PKT_GEN_ABORT_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_axis_pkt_gen;

  localparam int DATA_W = 32;
  localparam int KEEP_W = 4;
  localparam int LEN_W  = 16;
  localparam int GAP_W  = 8;

  logic              aclk = 1'b0;
  logic              areset;
  logic              start;
  logic [LEN_W-1:0]  pkt_len_bytes;
  logic [15:0]       pkt_count;
  logic [GAP_W-1:0]  gap_cycles;
  logic [DATA_W-1:0] seed;
  logic              busy;
  logic              done;
  logic [15:0]       pkts_sent;
`ifdef AXIS_PKT_GEN_ABORT_EN
  logic              abort;
`endif

  axis_pkt_gen_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W)) axis ();

  axis_pkt_gen #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .LEN_W(LEN_W), .GAP_W(GAP_W)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .start         (start),
    .pkt_len_bytes (pkt_len_bytes),
    .pkt_count     (pkt_count),
    .gap_cycles    (gap_cycles),
    .seed          (seed),
`ifdef AXIS_PKT_GEN_ABORT_EN
    .abort         (abort),
`endif
    .busy          (busy),
    .done          (done),
    .pkts_sent     (pkts_sent),
    .m_axis        (axis)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic              user;
  } beat_t;

  beat_t exp_q[$];
  int    compared   = 0;
  int    mismatched = 0;
  int    cyc        = 0;
  int    last_xfer_cyc = 0;
  int    xfer_count = 0;
  int    idle_run   = 0;
  int    exp_gap    = 0;
  bit    after_last = 1'b0;
  bit    stall_pend = 1'b0;
  beat_t held;

  always @(posedge aclk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pop, stall stability and gap length.
  always @(negedge aclk) begin
    beat_t got;
    beat_t e;
    got = {axis.tdata, axis.tkeep, axis.tlast, axis.tuser};
    if (areset) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        check("stall_valid", 64'(axis.tvalid), 64'd1);
        check("stall_hold", 64'(got), 64'(held));
      end
      if (axis.tvalid) begin
        if (after_last) begin
          check("gap_len", 64'(idle_run), 64'(exp_gap));
          after_last = 1'b0;
        end
        if (axis.tready) begin
          xfer_count++;
          last_xfer_cyc = cyc;
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
          check("beat", 64'(got), 64'(e));
          if (axis.tlast) begin
            after_last = 1'b1;
            idle_run   = 0;
          end
        end
        stall_pend = !axis.tready;
        held       = got;
      end else begin
        stall_pend = 1'b0;
        if (after_last) idle_run++;
      end
    end
  end

  task automatic push_run(input int len, input int count, input logic [DATA_W-1:0] sd);
    int nb;
    logic [DATA_W-1:0] d;
    beat_t e;
    nb = (len + KEEP_W - 1) / KEEP_W;
    d  = sd;
    for (int p = 0; p < count; p++) begin
      for (int b = 0; b < nb; b++) begin
        e.data = d;
        e.keep = (b == nb - 1 && (len % KEEP_W) != 0) ? KEEP_W'((1 << (len % KEEP_W)) - 1) : '1;
        e.last = (b == nb - 1);
        e.user = (b == 0);
        exp_q.push_back(e);
        d = d + 1;
      end
    end
  endtask

  task automatic do_start(input int len, input int count, input int gap, input logic [DATA_W-1:0] sd);
    @(posedge aclk); #1;
    pkt_len_bytes = LEN_W'(len);
    pkt_count     = 16'(count);
    gap_cycles    = GAP_W'(gap);
    seed          = sd;
    after_last    = 1'b0;
    exp_gap       = gap;
    start         = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
  endtask

  // mode 0: tready always high; mode 1: tready pattern 1,0,0,1 repeating.
  task automatic wait_done(input int mode, output int done_at);
    bit seen;
    seen    = 1'b0;
    done_at = -1;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        seen    = 1'b1;
        done_at = cyc;
        break;
      end
      axis.tready = (mode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
      @(posedge aclk); #1;
    end
    if (!seen) check("done_timeout", 64'(done), 64'd1);
    axis.tready = 1'b1;
  endtask

  int done_at;
  int done_cnt;
  int valid_cnt;

  initial begin
    areset        = 1'b1;
    start         = 1'b0;
    pkt_len_bytes = '0;
    pkt_count     = '0;
    gap_cycles    = '0;
    seed          = '0;
    axis.tready   = 1'b1;
`ifdef AXIS_PKT_GEN_ABORT_EN
    abort         = 1'b0;
`endif
    repeat (3) @(posedge aclk);
    #1;
    check("reset_outputs",
          64'({axis.tvalid, axis.tdata, axis.tkeep, axis.tlast, axis.tuser, busy, done, pkts_sent}), 64'd0);
    areset = 1'b0;

    // Two full beats, single packet
    push_run(8, 1, 32'h100);
    do_start(8, 1, 0, 32'h100);
    check("busy_after_start", 64'(busy), 64'd1);
    wait_done(0, done_at);
    check("t1_done_latency", 64'(done_at), 64'(last_xfer_cyc + 1));
    check("t1_pkts_sent", 64'(pkts_sent), 64'd1);
    check("t1_busy_at_done", 64'(busy), 64'd0);
    @(posedge aclk); #1;
    check("t1_done_pulse", 64'(done), 64'd0);
    check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

    // Partial last beat, idle gap of 2
    push_run(5, 3, 32'h0);
    do_start(5, 3, 2, 32'h0);
    wait_done(0, done_at);
    check("t2_pkts_sent", 64'(pkts_sent), 64'd3);
    check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

    // Back-to-back packets under backpressure with data wrap
    push_run(12, 2, 32'hFFFF_FFFE);
    do_start(12, 2, 0, 32'hFFFF_FFFE);
    wait_done(1, done_at);
    check("t3_done_latency", 64'(done_at), 64'(last_xfer_cyc + 1));
    check("t3_pkts_sent", 64'(pkts_sent), 64'd2);
    check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

    // Zero length and zero count send nothing but still pulse done
    for (int k = 0; k < 2; k++) begin
      do_start((k == 0) ? 0 : 8, (k == 0) ? 3 : 0, 0, 32'h77);
      done_cnt  = 0;
      valid_cnt = 0;
      for (int i = 0; i < 5; i++) begin
        if (done) done_cnt++;
        if (axis.tvalid || busy) valid_cnt++;
        @(posedge aclk); #1;
      end
      check("zero_done_once", 64'(done_cnt), 64'd1);
      check("zero_no_beats", 64'(valid_cnt), 64'd0);
      check("zero_pkts_sent", 64'(pkts_sent), 64'd0);
    end

    // Starts while busy and in the DONE cycle are ignored
    push_run(8, 2, 32'h50);
    do_start(8, 2, 1, 32'h50);
    pkt_count = 16'd7;
    start     = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    wait_done(0, done_at);
    start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    check("t5_busy_after_done_start", 64'(busy), 64'd0);
    repeat (3) @(posedge aclk);
    #1;
    check("t5_idle_no_valid", 64'(axis.tvalid), 64'd0);
    check("t5_pkts_sent", 64'(pkts_sent), 64'd2);
    check("t5_queue_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset after the first of four beats
    push_run(4, 1, 32'h200);
    exp_q.delete();
    begin
      beat_t e;
      e.data = 32'h200; e.keep = '1; e.last = 1'b0; e.user = 1'b1;
      exp_q.push_back(e);
    end
    do_start(16, 1, 0, 32'h200);
    @(posedge aclk); #1;
    areset = 1'b1;
    #1;
    check("midreset_outputs",
          64'({axis.tvalid, axis.tdata, axis.tkeep, axis.tlast, axis.tuser, busy, done, pkts_sent}), 64'd0);
    check("midreset_one_beat", 64'(exp_q.size()), 64'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    push_run(16, 1, 32'h200);
    do_start(16, 1, 0, 32'h200);
    check("restart_first_beat", 64'({axis.tvalid, axis.tuser, axis.tdata}), {30'd0, 1'b1, 1'b1, 32'h200});
    wait_done(0, done_at);
    check("t6_pkts_sent", 64'(pkts_sent), 64'd1);
    check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

`ifdef AXIS_PKT_GEN_ABORT_EN
    // Abort during packet 3 beat 1: packet 3 completes, then DONE
    begin
      bit pulsed;
      bit seen;
      pulsed = 1'b0;
      seen   = 1'b0;
      push_run(16, 3, 32'h1000);
      xfer_count = 0;
      do_start(16, 10, 0, 32'h1000);
      for (int i = 0; i < 200; i++) begin
        if (done) begin
          seen    = 1'b1;
          done_at = cyc;
          break;
        end
        abort = (xfer_count == 9 && !pulsed);
        if (abort) pulsed = 1'b1;
        @(posedge aclk); #1;
      end
      abort = 1'b0;
      if (!seen) check("abort_done_timeout", 64'(done), 64'd1);
      check("abort_done_latency", 64'(done_at), 64'(last_xfer_cyc + 1));
      check("abort_pkts_sent", 64'(pkts_sent), 64'd3);
      check("abort_queue_empty", 64'(exp_q.size()), 64'd0);
    end
`endif

    repeat (4) @(posedge aclk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
